// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side valid/ready streams and FIFO write port shared by fifo_wr_arbiter.
// The slave modport is the arbiter's view; the master modport is the producers/FIFO view.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_ready;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;

    modport slave (
        input  req_valid, req_data, fifo_wr_ready,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );

    modport master (
        output req_valid, req_data, fifo_wr_ready,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Define FIFO_ARB_BURST_EN to hold a grant for up to BURST_LEN accepted beats.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input logic              clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || BURST_LEN < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_grant_id, w_grant_id_nxt;
    logic [ID_W-1:0] r_last_grant, w_last_grant_nxt;
    logic [ID_W-1:0] w_arb_ptr;
    logic [ID_W-1:0] w_winner;
    logic            w_any_req;
    logic            w_gnt_valid;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_release;

    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan ptr+1 .. ptr+NUM_REQ; descending overwrite leaves the nearest requester.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0] ptr,
                                                input logic [NUM_REQ-1:0] vld);
        logic [ID_W-1:0] win;
        int unsigned     idx;
        win = ptr;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (vld[idx]) win = ID_W'(idx);
        end
        return win;
    endfunction

    assign w_arb_ptr   = (r_state == S_GRANT) ? r_grant_id : r_last_grant;
    assign w_winner    = rr_pick(w_arb_ptr, bus.req_valid);
    assign w_any_req   = |bus.req_valid;
    assign w_gnt_valid = bus.req_valid[r_grant_id];
    assign w_accept    = (r_state == S_GRANT) && w_gnt_valid && bus.fifo_wr_ready;
    assign w_release   = (r_state == S_GRANT) && (!w_gnt_valid || (w_accept && w_last_beat));

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;

    assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));

    // Counts accepted beats of the current grant; cleared whenever the grant ends.
    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_release)     w_beat_cnt_nxt = '0;
        else if (w_accept) w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_beat_cnt <= '0;
        else        r_beat_cnt <= w_beat_cnt_nxt;
    end
`else
    assign w_last_beat = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Release and re-arbitration share one edge so a pending request sees no bubble.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_id_nxt = w_winner;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_last_grant_nxt = r_grant_id;
                    if (w_any_req) w_grant_id_nxt = w_winner;
                    else           w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO write port and producer ready follow the grantee combinationally.
    always_comb begin
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = '0;
        if (r_state == S_GRANT) begin
            bus.fifo_wr_en            = w_gnt_valid;
            bus.fifo_wr_data          = w_data_arr[r_grant_id];
            bus.req_ready[r_grant_id] = w_accept;
        end
    end

    assign bus.grant_valid = (r_state == S_GRANT);
    assign bus.grant_id    = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers drain per-source queues, every accepted
// beat is compared against the expected (grant_id, data) order derived from the arbitration rules.
module tb_fifo_wr_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned BURST_LEN  = 4;
    localparam int unsigned ID_W       = $clog2(NUM_REQ);
`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned LIMIT = BURST_LEN;
`else
    localparam int unsigned LIMIT = 1;
`endif

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic fifo_rdy;
    int   n_err = 0;
    int   n_chk = 0;
    int   n_acc;
    int   n_bubble;

    beat_t                 exp_q [$];
    logic [DATA_WIDTH-1:0] src_q [NUM_REQ][$];

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = (src_q[i].size() > 0);
            bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        bus.fifo_wr_ready = fifo_rdy;
    endtask

    task automatic add_beat(input int id, input int data);
        beat_t b;
        b.id   = ID_W'(id);
        b.data = DATA_WIDTH'(data);
        src_q[id].push_back(b.data);
        exp_q.push_back(b);
    endtask

    // Monitor on the falling edge, then let the accepted producer advance after the rising edge.
    task automatic cycle();
        beat_t e;
        int    acc_id;
        acc_id = -1;
        @(negedge clk);
        if (bus.req_ready != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 32'(bus.req_ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat_ready", 32'(bus.req_ready), 32'(1) << e.id);
                check_eq("beat_id",    32'(bus.grant_id), 32'(e.id));
                check_eq("beat_data",  32'(bus.fifo_wr_data), 32'(e.data));
                check_eq("beat_en_gv", {30'd0, bus.fifo_wr_en, bus.grant_valid}, 32'd3);
            end
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) acc_id = i;
            n_acc++;
        end else if (n_acc > 0 && fifo_rdy && exp_q.size() > 0) begin
            n_bubble++;
        end
        @(posedge clk);
        #1;
        if (acc_id >= 0 && src_q[acc_id].size() > 0) void'(src_q[acc_id].pop_front());
        drive();
    endtask

    task automatic run_until_acc(input int target, input int budget);
        int c;
        c = 0;
        while (n_acc < target && c < budget) begin
            cycle();
            c++;
        end
        check_eq("acc_reached", 32'(n_acc >= target), 32'd1);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < 400) begin
            cycle();
            c++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fifo_rdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_acc    = 0;
        n_bubble = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        fifo_rdy = 1'b1;
        n_acc    = 0;
        n_bubble = 0;
        bus.req_valid     = '1;
        bus.req_data      = '1;
        bus.fifo_wr_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gv",    32'(bus.grant_valid), 32'd0);
        check_eq("rst_gid",   32'(bus.grant_id), 32'd0);
        check_eq("rst_en",    32'(bus.fifo_wr_en), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_data",  32'(bus.fifo_wr_data), 32'd0);

        // Single beat from producer 0, one-cycle arbitration latency.
        do_reset();
        add_beat(0, 8'hA5);
        drive();
        @(negedge clk);
        check_eq("lat_gv", 32'(bus.grant_valid), 32'd0);
        check_eq("lat_en", 32'(bus.fifo_wr_en), 32'd0);
        @(posedge clk);
        #1;
        drain("drain_single");
        check_eq("idle_gv", 32'(bus.grant_valid), 32'd0);
        check_eq("idle_en", 32'(bus.fifo_wr_en), 32'd0);

        // All producers continuously valid: rotation 0,1,2,3 in blocks of LIMIT, no bubbles.
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int id = 0; id < NUM_REQ; id++)
                for (int k = 0; k < int'(LIMIT); k++) add_beat(id, id*16 + r*int'(LIMIT) + k);
        drive();
        drain("drain_all4");
        check_eq("bubbles_all4", 32'(n_bubble), 32'd0);

        // Producers 1 and 2 alternate, producer 1 first after reset.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int id = 1; id <= 2; id++)
                for (int k = 0; k < int'(LIMIT); k++) add_beat(id, id*16 + r*int'(LIMIT) + k);
        drive();
        drain("drain_p12");
        check_eq("bubbles_p12", 32'(n_bubble), 32'd0);

        // Backpressure for 3 cycles after two accepted beats; burst must resume where it stopped.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int id = 0; id <= 1; id++)
                for (int k = 0; k < int'(LIMIT); k++) add_beat(id, id*16 + r*int'(LIMIT) + k);
        drive();
        run_until_acc(2, 50);
        fifo_rdy = 1'b0;
        drive();
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_eq("bp_ready", 32'(bus.req_ready), 32'd0);
            check_eq("bp_gv_en", {30'd0, bus.grant_valid, bus.fifo_wr_en}, 32'd3);
            if (exp_q.size() > 0) begin
                check_eq("bp_gid",  32'(bus.grant_id), 32'(exp_q[0].id));
                check_eq("bp_data", 32'(bus.fifo_wr_data), 32'(exp_q[0].data));
            end
            @(posedge clk);
            #1;
        end
        fifo_rdy = 1'b1;
        drive();
        drain("drain_bp");
        check_eq("bubbles_bp", 32'(n_bubble), 32'd0);

        // Grantee drops valid while producer 3 waits; producer 3's count starts from zero.
        do_reset();
`ifdef FIFO_ARB_BURST_EN
        add_beat(0, 8'h00);
        add_beat(0, 8'h01);
        for (int k = 0; k < 4; k++) add_beat(3, 8'h30 + k);
        begin
            beat_t b;
            b.id = ID_W'(0); b.data = 8'h02; exp_q.push_back(b);
            b.id = ID_W'(3); b.data = 8'h34; exp_q.push_back(b);
            src_q[3].push_back(8'h34);
        end
        drive();
        run_until_acc(3, 50);
        src_q[0].push_back(8'h02);
        drive();
`else
        add_beat(0, 8'h00);
        add_beat(3, 8'h30);
        add_beat(0, 8'h01);
        add_beat(3, 8'h31);
        drive();
`endif
        drain("drain_drop");

        // Asynchronous reset mid-burst, then arbitration restarts at producer 0.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int id = 0; id < NUM_REQ; id++)
                for (int k = 0; k < int'(LIMIT); k++) add_beat(id, id*16 + r*int'(LIMIT) + k);
        drive();
        run_until_acc(2, 50);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_gv",    32'(bus.grant_valid), 32'd0);
        check_eq("arst_en",    32'(bus.fifo_wr_en), 32'd0);
        check_eq("arst_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        for (int id = 0; id < NUM_REQ; id++)
            for (int k = 0; k < int'(LIMIT); k++) add_beat(id, 8'h80 + id*16 + k);
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_acc    = 0;
        n_bubble = 0;
        drain("drain_arst");
        check_eq("bubbles_arst", 32'(n_bubble), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write interface of the team's synchronous FIFO between `NUM_REQ` independent producers. Each producer presents a valid/ready stream; the arbiter grants one producer at a time, muxes its data onto the FIFO write port, and honours FIFO backpressure. It sits directly in front of the FIFO, with `fifo_wr_*` wired to the FIFO's `wr_en`/`wr_data`/`wr_ready`.

## Interface
- `NUM_REQ`, 4: number of producers; must be at least 2.
- `DATA_WIDTH`, 8: data bus width, equal to the FIFO's `DATA_WIDTH`.
- `BURST_LEN`, 4: maximum accepted beats per grant when `FIFO_ARB_BURST_EN` is defined; must be at least 1.
- Reset is asynchronous and active-low (`rst_n`); the block uses one clock (`clk`).
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  bit i set means producer i holds a beat.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer i data in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  `NUM_REQ`  bit i set means producer i's beat is accepted this cycle.
- `fifo_wr_en`  out  1  write strobe to the FIFO.
- `fifo_wr_data`  out  `DATA_WIDTH`  write data to the FIFO.
- `fifo_wr_ready`  in  1  the FIFO can accept a write (not full).
- `grant_valid`  out  1  a grant is currently held.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the granted producer.

## Operation
- The arbiter has two states:
  - IDLE: `grant_valid`=0.
  - GRANT: `grant_valid`=1, and `grant_id` is registered.
- Selection uses a round-robin pointer `last_grant`. The winner is the first i with `req_valid[i]` set, scanning `last_grant+1, last_grant+2, …` modulo `NUM_REQ`. `last_grant` itself is checked last.
- IDLE → GRANT: if any `req_valid` bit is set, load `grant_id` with the winner on the next edge.
- In GRANT, these outputs are combinational:
  - `fifo_wr_en = req_valid[grant_id]`.
  - `fifo_wr_data = req_data[grant_id]`.
  - `req_ready[grant_id] = fifo_wr_ready & req_valid[grant_id]`.
  - All other `req_ready` bits are 0.
- A beat is accepted when `req_valid[grant_id] & fifo_wr_ready`. The beat counter increments only on an accepted beat.
- The grant is released on the edge where either of these holds:
  - the accepted-beat count reaches its limit (1 without burst, `BURST_LEN` with burst), or
  - `req_valid[grant_id]` is 0.
- On release:
  - `last_grant <= grant_id`.
  - The arbiter re-arbitrates in the same cycle using the updated pointer. If any request is pending, it goes straight to GRANT with the new winner (no bubble); otherwise it goes to IDLE.
  - The beat counter clears to 0.
- Backpressure: while `fifo_wr_ready`=0, the grant, `grant_id` and the beat counter hold. A producer must keep `req_valid` and `req_data` stable until its `req_ready` is asserted.
- The arbiter never asserts `fifo_wr_en` while IDLE. The FIFO itself suppresses writes while full.
- The beat counter is `$clog2(BURST_LEN+1)` bits wide. It never exceeds `BURST_LEN`.

## Timing
- Reset values (applied asynchronously, immediately on `rst_n` low):
  - state = IDLE, `grant_valid`=0, `grant_id`=0.
  - `last_grant`=`NUM_REQ-1`, so producer 0 wins first.
  - beat counter = 0.
  - `fifo_wr_en`=0, `req_ready`=0, `fifo_wr_data`=0.
- Arbitration latency from IDLE is 1 cycle: `req_valid` set at edge n gives `grant_valid` and `fifo_wr_en` after edge n+1.
- Throughput is 1 beat/cycle, including across grant changes when requests are pending.
- There is a combinational path `fifo_wr_ready` → `req_ready`. There is no combinational path from `req_valid` to `grant_id`.
- Reset asserted mid-burst aborts the grant. A partial burst is not resumed, and arbitration restarts from producer 0.

## Configuration
- Macro: `FIFO_ARB_BURST_EN`.
- Defined: a grant is held for up to `BURST_LEN` accepted beats while the grantee stays valid, and the beat counter is implemented.
- Undefined: each grant covers exactly one accepted beat, the beat counter is removed, and `BURST_LEN` is ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then `req_valid`=4'b0001 with producer 0 data 0xA5 → cycle 1: `grant_valid`=1, `grant_id`=0, `fifo_wr_en`=1, `fifo_wr_data`=0xA5, `req_ready`=4'b0001.
- Burst disabled, all four producers continuously valid, `fifo_wr_ready`=1 → `grant_id` sequence 0,1,2,3,0,1…, one beat each, no idle cycles.
- Burst enabled, `BURST_LEN`=4, producers 1 and 2 continuously valid → 4 beats from 1, then 4 from 2, then 4 from 1, with no bubble at the switch.
- `fifo_wr_ready` held low for 3 cycles mid-grant → `req_ready`=0, `grant_id` and `fifo_wr_data` stable, beat count frozen; the burst resumes its remaining beats afterwards.
- Burst enabled, the grantee drops `req_valid` after 2 beats while producer 3 is valid → release; producer 3 is granted on the next edge, and its count starts at 0.
- `rst_n` pulsed low asynchronously mid-burst → `grant_valid`, `fifo_wr_en` and `req_ready` go to 0 immediately; after release with all producers valid, producer 0 is granted first.
